// File: rtl/matmul_seq.sv
// Matrix-multiply sequencer: latches A and B, walks every (row, column) pair
// through an external inner-product unit and collects the NxN product matrix.
module matmul_seq #(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*N*W-1:0]     mat_a,
  input  logic [N*N*W-1:0]     mat_b,
  input  logic [W-1:0]         prod_in,
  input  logic                 ovf_in,
  output logic [N*W-1:0]       lin,
  output logic [N*W-1:0]       col,
  output logic [N*N*W-1:0]     result,
  output logic                 ovf,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [IW-1:0]         i_r;
  logic [IW-1:0]         j_r;
  logic [N*N*W-1:0]      a_lat_r;
  logic [N*N*W-1:0]      b_lat_r;
  logic                  last_s;

  assign last_s = (i_r == IW'(N-1)) && (j_r == IW'(N-1));

  // Next-state decode; start is only honoured in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Present row i of A and column j of B to the inner-product unit.
  always_comb begin
    lin = '0;
    col = '0;
    for (int m = 0; m < N; m++) begin
      lin[W*(N-1-m) +: W] = a_lat_r[W*(N*N-1-(int'(i_r)*N+m)) +: W];
      col[W*(N-1-m) +: W] = b_lat_r[W*(N*N-1-(m*N+int'(j_r))) +: W];
    end
  end

  // State, operand latches, index walk and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      i_r     <= '0;
      j_r     <= '0;
      a_lat_r <= '0;
      b_lat_r <= '0;
      result  <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s == RUN);
      done    <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_lat_r <= mat_a;
            b_lat_r <= mat_b;
            i_r     <= '0;
            j_r     <= '0;
            result  <= '0;
            ovf     <= 1'b0;
          end
        end
        RUN: begin
          result[W*(N*N-1-(int'(i_r)*N+int'(j_r))) +: W] <= prod_in;
          ovf <= ovf | ovf_in;
          // Row-major walk; wraps to (0,0) after the last element.
          if (j_r == IW'(N-1)) begin
            j_r <= '0;
            if (last_s) i_r <= '0;
            else        i_r <= i_r + IW'(1);
          end else begin
            j_r <= j_r + IW'(1);
          end
        end
        DONE: begin
          i_r <= '0;
          j_r <= '0;
        end
        default: begin
          i_r <= '0;
          j_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Scoreboard bench for matmul_seq with a saturating behavioural inner-product unit.
module tb_matmul_seq;
  localparam int N  = 5;
  localparam int W  = 8;
  localparam int MW = N*N*W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [MW-1:0] mat_a, mat_b, result;
  logic [W-1:0]  prod_in;
  logic          ovf_in;
  logic [N*W-1:0] lin, col;
  logic          ovf, busy, done;

  typedef struct {
    logic [MW-1:0] res;
    logic          ov;
  } exp_t;
  exp_t sbq[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  matmul_seq #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .mat_a(mat_a), .mat_b(mat_b),
    .prod_in(prod_in), .ovf_in(ovf_in), .lin(lin), .col(col),
    .result(result), .ovf(ovf), .busy(busy), .done(done)
  );

  // Inner-product unit stand-in: signed dot product, saturating to W bits.
  always_comb begin
    int s;
    s = 0;
    for (int m = 0; m < N; m++)
      s += int'($signed(lin[W*(N-1-m) +: W])) * int'($signed(col[W*(N-1-m) +: W]));
    if (s > 127) begin
      prod_in = 8'h7F; ovf_in = 1'b1;
    end else if (s < -128) begin
      prod_in = 8'h80; ovf_in = 1'b1;
    end else begin
      prod_in = W'(s); ovf_in = 1'b0;
    end
  end

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] setel(input logic [MW-1:0] m, input int r, input int c,
                                          input logic [W-1:0] v);
    logic [MW-1:0] t;
    t = m;
    t[W*(N*N-1-(r*N+c)) +: W] = v;
    return t;
  endfunction

  function automatic logic [MW-1:0] fill(input logic [W-1:0] v);
    logic [MW-1:0] t;
    t = '0;
    for (int k = 0; k < N*N; k++) t[W*k +: W] = v;
    return t;
  endfunction

  function automatic logic [MW-1:0] ident();
    logic [MW-1:0] t;
    t = '0;
    for (int r = 0; r < N; r++) t = setel(t, r, r, 8'd1);
    return t;
  endfunction

  function automatic logic [MW-1:0] seq25();
    logic [MW-1:0] t;
    t = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) t = setel(t, r, c, W'(r*N+c+1));
    return t;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        e = sbq.pop_front();
        check("result", result, e.res);
        check("ovf", ovf, e.ov);
      end
    end
  end

  task automatic run(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic [MW-1:0] er,
                     input logic eo, input bit hold, input bit perturb);
    int   cyc;
    int   bc;
    exp_t e;
    @(negedge clk);
    mat_a = a; mat_b = b; start = 1'b1;
    e.res = er; e.ov = eo;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    cyc = 0; bc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      if (done) break;
      if (busy) bc++;
      cyc++;
      if (perturb && cyc == 10) mat_a = fill(8'h7F);
    end
    start = 1'b0;
    check("latency", cyc, 25);
    check("busy_cycles", bc, 25);
    @(negedge clk);
    check("done_width", done, 1'b0);
    check("busy_after", busy, 1'b0);
  endtask

  logic [MW-1:0] b3;
  int dones;

  initial begin
    rst = 1'b1; start = 1'b0; mat_a = '0; mat_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, '0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_lin", lin, '0);
    check("rst_col", col, '0);
    @(negedge clk); rst = 1'b0;

    run(ident(), seq25(), seq25(), 1'b0, 1'b0, 1'b0);
    run(fill(8'd1), fill(8'd2), fill(8'd10), 1'b0, 1'b0, 1'b0);

    // B column 0 = 2,3,-2,1,-2, rest 0; A all -1 gives C(i,0) = -2.
    b3 = '0;
    b3 = setel(b3, 0, 0, 8'd2);  b3 = setel(b3, 1, 0, 8'd3);
    b3 = setel(b3, 2, 0, 8'hFE); b3 = setel(b3, 3, 0, 8'd1);
    b3 = setel(b3, 4, 0, 8'hFE);
    run(fill(8'hFF), b3,
        setel(setel(setel(setel(setel('0, 0, 0, 8'hFE), 1, 0, 8'hFE), 2, 0, 8'hFE), 3, 0, 8'hFE), 4, 0, 8'hFE),
        1'b0, 1'b0, 1'b0);

    run(fill(8'h7F), fill(8'h7F), fill(8'h7F), 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("ovf_held", ovf, 1'b1);
    check("result_held", result, fill(8'h7F));
    run(ident(), ident(), ident(), 1'b0, 1'b0, 1'b0);

    // start held high and A disturbed mid-run.
    run(ident(), seq25(), seq25(), 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("no_restart", busy, 1'b0);

    // Abort mid-run with reset.
    @(negedge clk);
    mat_a = fill(8'd1); mat_b = fill(8'd1); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", result, '0);
    check("abort_ovf", ovf, 1'b0);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    run(ident(), fill(8'd3), fill(8'd3), 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
